// File: rtl/ram_sync_param_pkg.sv
// Shared types for the parametrised synchronous RAM: clear-sequencer state encoding.
package ram_sync_param_pkg;

    typedef enum logic {
        RAM_ST_CLEAR = 1'b0,
        RAM_ST_READY = 1'b1
    } ram_state_t;

endpackage

// File: rtl/ram_sync_param_clear_seq.sv
// Clear sequencer: after reset, sweeps every address once (DEPTH cycles), then idles in READY.
// busy is high exactly while sweeping; no backpressure, the sweep cannot be stalled.
module ram_clear_seq
    import ram_sync_param_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    ram_state_t        state;
    ram_state_t        state_nxt;
    // One extra bit so the terminal count never aliases to address 0.
    logic [ADDR_W:0]   clr_cnt;
    logic [ADDR_W:0]   clr_cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RAM_ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        busy        = 1'b0;
        case (state)
            RAM_ST_CLEAR: begin
                clr_we      = 1'b1;
                busy        = 1'b1;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == (ADDR_W + 1)'(DEPTH - 1)) begin
                    state_nxt = RAM_ST_READY;
                end
            end
            RAM_ST_READY: begin
                state_nxt = RAM_ST_READY;
            end
            default: begin
                state_nxt = RAM_ST_CLEAR;
            end
        endcase
    end

    assign clr_addr = clr_cnt[ADDR_W-1:0];

endmodule

// File: rtl/ram_sync_param.sv
// Single-port sync RAM (csn/rwn protocol) with post-reset clear sweep; read latency 1 clk, rd_valid 1 cycle.
// No backpressure: accesses presented while busy are silently dropped. Optional RAM_PARITY_EN adds even parity.
module ram_sync_param
    import ram_sync_param_pkg::*;
#(
    parameter int                DATA_W   = 4,
    parameter int                ADDR_W   = 4,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csn,
    input  logic              rwn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              parity_err
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              we;
    logic              rd_en;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdat;
    logic [MEM_W-1:0]  wword;
    logic [MEM_W-1:0]  rd_word;
    logic [MEM_W-1:0]  mem [DEPTH];

    ram_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy)
    );

    // Write port is owned by the sequencer while busy, by the user port otherwise.
    assign we    = clr_we | (!busy && !csn && !rwn);
    assign rd_en = !busy && !csn && rwn;
    assign waddr = busy ? clr_addr : addr;
    assign wdat  = busy ? INIT_VAL : data_in;

`ifdef RAM_PARITY_EN
    assign wword = {^wdat, wdat};
`else
    assign wword = wdat;
`endif

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wword;
        end
    end

    assign rd_word = mem[addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                data_out <= rd_word[DATA_W-1:0];
            end
        end
    end

`ifdef RAM_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= rd_en && (^rd_word);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
